// File: rtl/video_paldither.sv
// Palette lookup, pixel/border mixer and 2x2 ordered dither feeding the video DAC.
// Two-clock pipeline: index -> palette entry -> dithered, blanked colour.
module video_paldither #(
  parameter int unsigned CH_BITS   = 4,
  parameter int unsigned OUT_BITS  = 2,
  parameter int unsigned PAL_ABITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_stb,
  input  logic                    hpix,
  input  logic                    vpix,
  input  logic                    hblank,
  input  logic                    vblank,
  input  logic                    hsync_start,
  input  logic                    vsync,
  input  logic [PAL_ABITS-1:0]    pixels,
  input  logic [PAL_ABITS-1:0]    border,
  input  logic                    border_sync,
  input  logic                    border_sync_ena,
  input  logic [1:0]              dith_mode,
  input  logic                    pal_we,
  input  logic                    pal_rd,
  input  logic [PAL_ABITS-1:0]    pal_addr,
  input  logic [3*CH_BITS-1:0]    pal_wdata,
  output logic [3*CH_BITS-1:0]    pal_rdata,
  output logic [3*OUT_BITS-1:0]   color
);

  localparam int unsigned PW   = 3 * CH_BITS;
  localparam int unsigned CW   = 3 * OUT_BITS;
  localparam int unsigned SW   = OUT_BITS + 2;
  localparam int unsigned NE   = 1 << CH_BITS;
  localparam int unsigned NPAL = 1 << PAL_ABITS;
  localparam logic [OUT_BITS-1:0] OMAX = '1;

  // Scaled level table: s = floor(c * (2^OUT_BITS-1) * 4 / (2^CH_BITS-1)).
  function automatic logic [NE*SW-1:0] build_tab();
    logic [NE*SW-1:0] t;
    int unsigned      s;
    t = '0;
    for (int unsigned c = 0; c < NE; c++) begin
      s = (c * ((32'd1 << OUT_BITS) - 32'd1) * 32'd4) / ((32'd1 << CH_BITS) - 32'd1);
      t[c*SW +: SW] = SW'(s);
    end
    return t;
  endfunction

  localparam logic [NE*SW-1:0] LVL_TAB = build_tab();

  function automatic logic [OUT_BITS-1:0] dith_ch(
    input logic [CH_BITS-1:0] c,
    input logic [1:0]         mode,
    input logic [1:0]         thr
  );
    logic [SW-1:0]       s;
    logic [OUT_BITS-1:0] lvl;
    logic [1:0]          frac;
    s    = LVL_TAB[SW*32'(c) +: SW];
    lvl  = s[SW-1:2];
    frac = s[1:0];
    if ((mode != 2'b00) && (frac > thr) && (lvl != OMAX)) begin
      return lvl + OUT_BITS'(1);
    end
    return lvl;
  endfunction

  logic [PW-1:0]        mem [NPAL];
  logic [PW-1:0]        ent_q;
  logic [PAL_ABITS-1:0] synced_border;
  logic [PAL_ABITS-1:0] vid_idx_c;
  logic [1:0]           x_cnt;
  logic                 y_cnt;
  logic [1:0]           ph_cnt;
  logic                 vsync_r;
  logic                 blank_d1;
  logic                 x_d1;
  logic                 y_d1;
  logic [1:0]           ph_d1;
  logic [1:0]           mode_d1;
  logic [1:0]           ph_eff_c;
  logic [1:0]           grid_idx_c;
  logic [1:0]           thr_c;
  logic [CW-1:0]        color_c;

  always_comb begin
    vid_idx_c = border_sync_ena ? synced_border : border;
    if (hpix && vpix) vid_idx_c = pixels;
  end

  // Palette storage; both read ports see pre-write contents on a collision.
  always_ff @(posedge clk) begin
    if (pal_we) mem[pal_addr] <= pal_wdata;
    ent_q <= mem[vid_idx_c];
  end

  // Bayer threshold {0,2;3,1} at the pipelined pixel position.
  always_comb begin
    ph_eff_c   = mode_d1[1] ? ph_d1 : 2'b00;
    grid_idx_c = {y_d1 ^ ph_eff_c[1], x_d1 ^ ph_eff_c[0]};
    thr_c      = 2'd0;
    case (grid_idx_c)
      2'b00:   thr_c = 2'd0;
      2'b01:   thr_c = 2'd2;
      2'b10:   thr_c = 2'd3;
      default: thr_c = 2'd1;
    endcase
    color_c = '0;
    if (!blank_d1) begin
      color_c = {dith_ch(ent_q[2*CH_BITS-1 -: CH_BITS], mode_d1, thr_c),
                 dith_ch(ent_q[PW-1 -: CH_BITS],        mode_d1, thr_c),
                 dith_ch(ent_q[CH_BITS-1:0],            mode_d1, thr_c)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt         <= '0;
      y_cnt         <= 1'b0;
      ph_cnt        <= '0;
      vsync_r       <= 1'b1;
      synced_border <= '0;
      blank_d1      <= 1'b1;
      x_d1          <= 1'b0;
      y_d1          <= 1'b0;
      ph_d1         <= '0;
      mode_d1       <= '0;
      color         <= '0;
      pal_rdata     <= '0;
    end else begin
      if (hsync_start) begin
        x_cnt <= '0;
        y_cnt <= ~y_cnt;
      end else if (pix_stb) begin
        x_cnt <= x_cnt + 2'd1;
      end
      vsync_r <= vsync;
      if (vsync && !vsync_r) ph_cnt <= ph_cnt + 2'd1;
      if (border_sync) synced_border <= border;
      if (pal_rd) pal_rdata <= mem[pal_addr];
      blank_d1 <= hblank | vblank;
      x_d1     <= x_cnt[0];
      y_d1     <= y_cnt;
      ph_d1    <= ph_cnt;
      mode_d1  <= dith_mode;
      color    <= color_c;
    end
  end

endmodule
